// File: rtl/vn_output_collector.sv
// Ordered FIFO collector for the edge adder's two VN output lanes: up to two
// pushes per cycle, first-word-fall-through drain, drop-and-flag on overflow.
module vn_output_collector #(
  parameter int DATA_TYPE = 32,
  parameter int DEPTH     = 8,
  parameter int ADDR_W    = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [2*DATA_TYPE-1:0] i_vn,
  input  logic [1:0]             i_vn_valid,
  output logic [DATA_TYPE-1:0]   o_data,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [ADDR_W:0]        o_count,
  output logic                   o_almost_full,
  output logic                   o_overflow,
  output logic [7:0]             o_drop_cnt
);

  localparam int CNT_W  = ADDR_W + 1;
  localparam int FREE_W = ADDR_W + 2;

  logic [DATA_TYPE-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]    rd_ptr;
  logic [ADDR_W-1:0]    wr_ptr;
  logic [CNT_W-1:0]     count;
  logic [CNT_W-1:0]     count_next;

  logic                 pop;
  logic [1:0]           n_push;
  logic [FREE_W-1:0]    free;
  logic [1:0]           accept;
  logic [1:0]           drop;
  logic [8:0]           drop_sum;
  logic [DATA_TYPE-1:0] lane0;
  logic [DATA_TYPE-1:0] lane1;
  logic [DATA_TYPE-1:0] first_word;

  assign lane0 = i_vn[DATA_TYPE-1:0];
  assign lane1 = i_vn[2*DATA_TYPE-1:DATA_TYPE];

  assign o_data        = mem[rd_ptr];
  assign o_valid       = (count != '0);
  assign o_count       = count;
  assign o_almost_full = (count >= CNT_W'(DEPTH - 1));

  always_comb begin
    pop    = o_valid & i_ready;
    n_push = {1'b0, i_vn_valid[0]} + {1'b0, i_vn_valid[1]};
    // A same-cycle pop frees one slot for this cycle's push.
    free   = FREE_W'(DEPTH) - FREE_W'(count) + FREE_W'(pop);
    accept = (free >= FREE_W'(n_push)) ? n_push : free[1:0];
    drop   = n_push - accept;
    // Lane order: lane0 takes the first slot whenever it is valid.
    first_word = i_vn_valid[0] ? lane0 : lane1;
    count_next = count + CNT_W'(accept) - CNT_W'(pop);
    drop_sum   = 9'(o_drop_cnt) + 9'(drop);
  end

  // NOTE: storage has no reset; occupancy and pointers alone define validity.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (accept != 2'd0) mem[wr_ptr] <= first_word;
      if (accept == 2'd2) mem[wr_ptr + ADDR_W'(1)] <= lane1;
    end
  end

  // NOTE: all state uses non-blocking assignments so every register sees
  // pre-edge values of its peers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      o_overflow <= 1'b0;
      o_drop_cnt <= '0;
    end else begin
      rd_ptr <= rd_ptr + ADDR_W'(pop);
      wr_ptr <= wr_ptr + ADDR_W'(accept);
      count  <= count_next;
      if (drop != 2'd0) o_overflow <= 1'b1;
      o_drop_cnt <= (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
    end
  end

endmodule

// File: tb/tb_vn_output_collector.sv
// Directed, table-driven bench for vn_output_collector with hand-computed
// expectations plus sequences for streaming, mid-stream reset and saturation.
module tb_vn_output_collector;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] i_vn;
  logic [1:0]  i_vn_valid;
  logic [31:0] o_data;
  logic        o_valid;
  logic        i_ready;
  logic [3:0]  o_count;
  logic        o_almost_full;
  logic        o_overflow;
  logic [7:0]  o_drop_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  vn_output_collector #(.DATA_TYPE(32), .DEPTH(8), .ADDR_W(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_vn         (i_vn),
    .i_vn_valid   (i_vn_valid),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_count      (o_count),
    .o_almost_full(o_almost_full),
    .o_overflow   (o_overflow),
    .o_drop_cnt   (o_drop_cnt)
  );

  typedef struct {
    logic        rst;
    logic [1:0]  valid;
    logic [31:0] lane0;
    logic [31:0] lane1;
    logic        ready;
    logic        exp_valid;
    logic [31:0] exp_data;
    logic [3:0]  exp_count;
    logic        exp_af;
    logic        exp_ovf;
    logic [7:0]  exp_drop;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs [NV];

  function automatic vec_t mk(logic r, logic [1:0] v, logic [31:0] l0, logic [31:0] l1,
                              logic rdy, logic ev, logic [31:0] ed, logic [3:0] ec,
                              logic eaf, logic eovf, logic [7:0] edr);
    vec_t t;
    t.rst = r; t.valid = v; t.lane0 = l0; t.lane1 = l1; t.ready = rdy;
    t.exp_valid = ev; t.exp_data = ed; t.exp_count = ec;
    t.exp_af = eaf; t.exp_ovf = eovf; t.exp_drop = edr;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs, clock it, and sample 1 ns after the edge.
  task automatic cycle(input logic r, input logic [1:0] v, input logic [31:0] l0,
                       input logic [31:0] l1, input logic rdy);
    rst = r; i_vn_valid = v; i_vn = {l1, l0}; i_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input logic ev, input logic [31:0] ed,
                             input logic [3:0] ec, input logic eaf, input logic eovf,
                             input logic [7:0] edr);
    check({tag, " o_valid"}, 32'(o_valid), 32'(ev));
    check({tag, " o_count"}, 32'(o_count), 32'(ec));
    check({tag, " o_almost_full"}, 32'(o_almost_full), 32'(eaf));
    check({tag, " o_overflow"}, 32'(o_overflow), 32'(eovf));
    check({tag, " o_drop_cnt"}, 32'(o_drop_cnt), 32'(edr));
    if (ev) check({tag, " o_data"}, o_data, ed);
  endtask

  initial begin
    // Reset held two cycles with both lanes valid and ready high.
    vecs[0]  = mk(0, 2'b11, 32'h1111_1111, 32'h2222_2222, 1, 0, 32'h0, 0, 0, 0, 0);
    vecs[1]  = mk(0, 2'b11, 32'h1111_1111, 32'h2222_2222, 1, 0, 32'h0, 0, 0, 0, 0);
    // Dual push ordering: lane0 first.
    vecs[2]  = mk(1, 2'b11, 32'h3F80_0000, 32'h4000_0000, 0, 1, 32'h3F80_0000, 2, 0, 0, 0);
    vecs[3]  = mk(1, 2'b00, 32'h0, 32'h0, 1, 1, 32'h4000_0000, 1, 0, 0, 0);
    vecs[4]  = mk(1, 2'b00, 32'h0, 32'h0, 1, 0, 32'h0, 0, 0, 0, 0);
    // Single lanes; data on the invalid lane must be ignored.
    vecs[5]  = mk(1, 2'b10, 32'hDEAD_BEEF, 32'hAAAA_AAAA, 0, 1, 32'hAAAA_AAAA, 1, 0, 0, 0);
    vecs[6]  = mk(1, 2'b01, 32'h5555_5555, 32'hCAFE_F00D, 0, 1, 32'hAAAA_AAAA, 2, 0, 0, 0);
    vecs[7]  = mk(1, 2'b00, 32'h0, 32'h0, 1, 1, 32'h5555_5555, 1, 0, 0, 0);
    vecs[8]  = mk(1, 2'b00, 32'h0, 32'h0, 1, 0, 32'h0, 0, 0, 0, 0);
    // Fill to 7, then a dual push drops lane1.
    vecs[9]  = mk(1, 2'b11, 32'd1, 32'd2, 0, 1, 32'd1, 2, 0, 0, 0);
    vecs[10] = mk(1, 2'b11, 32'd3, 32'd4, 0, 1, 32'd1, 4, 0, 0, 0);
    vecs[11] = mk(1, 2'b11, 32'd5, 32'd6, 0, 1, 32'd1, 6, 0, 0, 0);
    vecs[12] = mk(1, 2'b01, 32'd7, 32'd0, 0, 1, 32'd1, 7, 1, 0, 0);
    vecs[13] = mk(1, 2'b11, 32'd8, 32'd9, 0, 1, 32'd1, 8, 1, 1, 1);
    // Full with simultaneous pop: one accepted, one dropped.
    vecs[14] = mk(1, 2'b11, 32'hA, 32'hB, 1, 1, 32'd2, 8, 1, 1, 2);
    // Drain; 9 (dropped) and B (dropped) must never appear.
    vecs[15] = mk(1, 2'b00, 32'h0, 32'h0, 1, 1, 32'd3, 7, 1, 1, 2);
    vecs[16] = mk(1, 2'b00, 32'h0, 32'h0, 1, 1, 32'd4, 6, 0, 1, 2);
    vecs[17] = mk(1, 2'b00, 32'h0, 32'h0, 1, 1, 32'd5, 5, 0, 1, 2);
    vecs[18] = mk(1, 2'b00, 32'h0, 32'h0, 1, 1, 32'd6, 4, 0, 1, 2);
    vecs[19] = mk(1, 2'b00, 32'h0, 32'h0, 1, 1, 32'd7, 3, 0, 1, 2);
    vecs[20] = mk(1, 2'b00, 32'h0, 32'h0, 1, 1, 32'd8, 2, 0, 1, 2);
    vecs[21] = mk(1, 2'b00, 32'h0, 32'h0, 1, 1, 32'hA, 1, 0, 1, 2);
    vecs[22] = mk(1, 2'b00, 32'h0, 32'h0, 1, 0, 32'h0, 0, 0, 1, 2);

    for (int i = 0; i < NV; i++) begin
      cycle(vecs[i].rst, vecs[i].valid, vecs[i].lane0, vecs[i].lane1, vecs[i].ready);
      check_state($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_data,
                  vecs[i].exp_count, vecs[i].exp_af, vecs[i].exp_ovf, vecs[i].exp_drop);
    end

    // Streaming across pointer wrap: each word appears one cycle after push.
    for (int i = 0; i < 20; i++) begin
      cycle(1, 2'b01, 32'h100 + 32'(i), 32'hFFFF_FFFF, 1);
      check_state($sformatf("stream%0d", i), 1, 32'h100 + 32'(i), 1, 0, 1, 2);
    end

    // Mid-stream reset discards contents and clears the sticky flags.
    cycle(0, 2'b01, 32'h200, 32'h0, 1);
    check_state("midrst", 0, 32'h0, 0, 0, 0, 0);
    cycle(1, 2'b00, 32'h0, 32'h0, 1);
    check_state("postrst", 0, 32'h0, 0, 0, 0, 0);

    // Drop counter saturation: fill 8, then 128 dual pushes drop 256 words.
    for (int i = 0; i < 4; i++) cycle(1, 2'b11, 32'h300 + 32'(2*i), 32'h301 + 32'(2*i), 0);
    check_state("fill8", 1, 32'h300, 8, 1, 0, 0);
    for (int i = 0; i < 127; i++) cycle(1, 2'b11, 32'h0, 32'h0, 0);
    check_state("drop254", 1, 32'h300, 8, 1, 1, 254);
    cycle(1, 2'b11, 32'h0, 32'h0, 0);
    check_state("drop_sat", 1, 32'h300, 8, 1, 1, 255);
    cycle(1, 2'b01, 32'h0, 32'h0, 0);
    check_state("drop_hold", 1, 32'h300, 8, 1, 1, 255);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
